// File: rtl/softmax_head_scheduler.sv
// Sequences one shared softmax engine across MATRIX_NUM heads: launch, wait, write, gap, done.
// Optional engine watchdog enabled by defining SOFTMAX_SCHED_TIMEOUT_EN.
module softmax_head_scheduler #(
  parameter int unsigned MATRIX_NUM     = 12,
  parameter int unsigned HEAD_W         = 4,
  parameter int unsigned LAUNCH_GAP     = 1,
  parameter int unsigned ENGINE_LAT_MAX = 512
) (
  input  logic              clk_p,
  input  logic              rst_n,
  input  logic              input_valid_n,
  output logic [HEAD_W-1:0] head_sel,
  output logic              eng_valid_n,
  input  logic              eng_output_valid_n,
  output logic              wr_en_n,
  input  logic              sink_ready_n,
  output logic              busy,
  output logic              output_valid_n,
  output logic              error_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_WRITE, S_GAP, S_DONE
  } state_t;

  localparam logic [HEAD_W-1:0] HEAD_LAST = HEAD_W'(MATRIX_NUM - 1);
  localparam int unsigned       GAP_W     = (LAUNCH_GAP > 1) ? $clog2(LAUNCH_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((LAUNCH_GAP > 0) ? (LAUNCH_GAP - 1) : 0);

  state_t            r_state;
  state_t            w_state_next;
  logic [HEAD_W-1:0] r_head_sel;
  logic [HEAD_W-1:0] w_head_sel_next;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [GAP_W-1:0]  w_gap_cnt_next;
  logic              r_eng_valid_n;
  logic              r_wr_en_n;
  logic              r_busy;
  logic              r_output_valid_n;
  logic              w_timeout;

  always_comb begin
    w_state_next    = r_state;
    w_head_sel_next = r_head_sel;
    w_gap_cnt_next  = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (!input_valid_n) begin
          w_state_next    = S_LAUNCH;
          w_head_sel_next = '0;
        end
      end
      S_LAUNCH: w_state_next = S_WAIT;
      S_WAIT: begin
        // A real result wins over a watchdog expiry in the same cycle.
        if (!eng_output_valid_n) begin
          w_state_next = S_WRITE;
        end else if (w_timeout) begin
          w_state_next = S_DONE;
        end
      end
      S_WRITE: begin
        if (!sink_ready_n) begin
          if (r_head_sel == HEAD_LAST) begin
            w_state_next = S_DONE;
          end else begin
            w_head_sel_next = r_head_sel + 1'b1;
            w_gap_cnt_next  = '0;
            w_state_next    = (LAUNCH_GAP > 0) ? S_GAP : S_LAUNCH;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_next = S_LAUNCH;
        end else begin
          w_gap_cnt_next = r_gap_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_next    = S_IDLE;
        w_head_sel_next = '0;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they align with the state they decode.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_head_sel       <= '0;
      r_gap_cnt        <= '0;
      r_eng_valid_n    <= 1'b1;
      r_wr_en_n        <= 1'b1;
      r_busy           <= 1'b0;
      r_output_valid_n <= 1'b1;
    end else begin
      r_state          <= w_state_next;
      r_head_sel       <= w_head_sel_next;
      r_gap_cnt        <= w_gap_cnt_next;
      r_eng_valid_n    <= (w_state_next != S_LAUNCH);
      r_wr_en_n        <= (w_state_next != S_WRITE);
      r_busy           <= (w_state_next != S_IDLE);
      r_output_valid_n <= (w_state_next != S_DONE);
    end
  end

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
  localparam int unsigned      WD_W    = (ENGINE_LAT_MAX > 1) ? $clog2(ENGINE_LAT_MAX) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(ENGINE_LAT_MAX - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic [WD_W-1:0] w_wd_cnt_next;
  logic            r_error_n;
  logic            w_error_n_next;

  assign w_timeout = (r_wd_cnt == WD_LAST);

  always_comb begin
    w_wd_cnt_next  = r_wd_cnt;
    w_error_n_next = r_error_n;
    if (r_state == S_LAUNCH) begin
      w_wd_cnt_next = '0;
    end else if (r_state == S_WAIT) begin
      w_wd_cnt_next = r_wd_cnt + 1'b1;
    end
    if ((r_state == S_IDLE) && !input_valid_n) begin
      w_error_n_next = 1'b1;
    end else if ((r_state == S_WAIT) && eng_output_valid_n && w_timeout) begin
      w_error_n_next = 1'b0;
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt  <= '0;
      r_error_n <= 1'b1;
    end else begin
      r_wd_cnt  <= w_wd_cnt_next;
      r_error_n <= w_error_n_next;
    end
  end

  assign error_n = r_error_n;
`else
  assign w_timeout = 1'b0;
  assign error_n   = 1'b1;
`endif

  assign head_sel       = r_head_sel;
  assign eng_valid_n    = r_eng_valid_n;
  assign wr_en_n        = r_wr_en_n;
  assign busy           = r_busy;
  assign output_valid_n = r_output_valid_n;

endmodule

// File: tb/tb_softmax_head_scheduler.sv
// Randomized scoreboard bench for softmax_head_scheduler: an event-timeline model predicts
// every launch, write and done with its exact cycle; a monitor pops and compares.
module tb_softmax_head_scheduler;

  localparam int N   = 12;
  localparam int HW  = 4;
  localparam int G   = 1;
  localparam int LAT = 16;

  logic          clk_p = 1'b0;
  logic          rst_n;
  logic          input_valid_n;
  logic [HW-1:0] head_sel;
  logic          eng_valid_n;
  logic          eng_output_valid_n;
  logic          wr_en_n;
  logic          sink_ready_n;
  logic          busy;
  logic          output_valid_n;
  logic          error_n;

  softmax_head_scheduler #(
    .MATRIX_NUM(N), .HEAD_W(HW), .LAUNCH_GAP(G), .ENGINE_LAT_MAX(LAT)
  ) dut (
    .clk_p(clk_p), .rst_n(rst_n), .input_valid_n(input_valid_n), .head_sel(head_sel),
    .eng_valid_n(eng_valid_n), .eng_output_valid_n(eng_output_valid_n), .wr_en_n(wr_en_n),
    .sink_ready_n(sink_ready_n), .busy(busy), .output_valid_n(output_valid_n), .error_n(error_n)
  );

  always #5 clk_p = ~clk_p;

  typedef struct { int kind; int head; int cyc; bit err; } ev_t;  // kind 0=launch 1=write 2=done
  ev_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   [N];
  int stall [N];
  int noresp_head = -1;
  bit spur_en = 1'b0;

  always @(posedge clk_p) cyc <= cyc + 1;

  // Expected timeline: launch at t, write completes at t+lat+1+stall, next launch one gap later.
  function automatic void build_run(input int b, input int noresp);
    int t;
    int wr;
    t = 1;
    for (int h = 0; h < N; h++) begin
      exp_q.push_back('{0, h, b + t, 1'b0});
      if (h == noresp) begin
        exp_q.push_back('{2, 0, b + t + LAT + 1, 1'b1});
        return;
      end
      wr = t + lat[h] + 1 + stall[h];
      exp_q.push_back('{1, h, b + wr, 1'b0});
      if (h == N - 1) exp_q.push_back('{2, 0, b + wr + 1, 1'b0});
      t = wr + 1 + G;
    end
  endfunction

  task automatic check_val(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    bit  exp_err_n;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: unexpected kind=%0d head=%0d at cyc=%0d", kind, head_sel, cyc);
    end else begin
      e = exp_q.pop_front();
      exp_err_n = (kind == 2) ? !e.err : 1'b1;
      if (e.kind != kind || e.cyc != cyc || (kind != 2 && e.head != int'(head_sel)) ||
          error_n != exp_err_n) begin
        n_err++;
        $display("FAIL event: got kind=%0d head=%0d cyc=%0d err_n=%0b, expected kind=%0d head=%0d cyc=%0d err_n=%0b",
                 kind, head_sel, cyc, error_n, e.kind, e.head, e.cyc, exp_err_n);
      end else begin
        $display("event kind=%0d head=%0d cyc=%0d err_n=%0b ok", kind, head_sel, cyc, error_n);
      end
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, after the drivers have settled.
  initial begin
    forever begin
      @(negedge clk_p);
      #2;
      if (rst_n) begin
        if (!eng_valid_n) check_event(0);
        if (!wr_en_n) begin
          if (!sink_ready_n) begin
            check_event(1);
          end else if (exp_q.size() == 0 || exp_q[0].kind != 1 || exp_q[0].head != int'(head_sel)) begin
            n_vec++;
            n_err++;
            $display("FAIL write_hold: head_sel=%0d held with no matching pending write", head_sel);
          end
        end
        if (!output_valid_n) check_event(2);
        if (int'(head_sel) > N - 1) begin
          n_vec++;
          n_err++;
          $display("FAIL head_range: head_sel=%0d, limit %0d", head_sel, N - 1);
        end
      end
    end
  end

  // Engine model: answers each launch after lat[head] cycles, optional stray result strobes.
  initial begin
    int  resp_cnt;
    bit  is_gap;
    resp_cnt = -1;
    eng_output_valid_n = 1'b1;
    forever begin
      @(negedge clk_p);
      if (!rst_n) begin
        resp_cnt = -1;
        eng_output_valid_n = 1'b1;
      end else begin
        is_gap = busy && eng_valid_n && wr_en_n && output_valid_n && (resp_cnt < 0);
        eng_output_valid_n = 1'b1;
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            eng_output_valid_n = 1'b0;
            resp_cnt = -1;
          end
        end
        if (!eng_valid_n) begin
          resp_cnt = (int'(head_sel) != noresp_head) ? lat[head_sel] : -1;
          if (spur_en) eng_output_valid_n = 1'b0;
        end
        if (spur_en && (!wr_en_n || is_gap) && $urandom_range(0, 1) == 1) eng_output_valid_n = 1'b0;
      end
    end
  end

  // Sink model: holds off stall[head] cycles on each write, random level while not writing.
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    sink_ready_n = 1'b1;
    forever begin
      @(negedge clk_p);
      if (!rst_n) begin
        stall_cnt = 0;
        sink_ready_n = 1'b1;
      end else if (!wr_en_n) begin
        if (stall_cnt < stall[head_sel]) begin
          sink_ready_n = 1'b1;
          stall_cnt++;
        end else begin
          sink_ready_n = 1'b0;
          stall_cnt = 0;
        end
      end else begin
        sink_ready_n = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic set_profile(input int fixed_lat, input bit rnd);
    for (int h = 0; h < N; h++) begin
      lat[h]   = rnd ? int'($urandom_range(1, 8)) : fixed_lat;
      stall[h] = rnd ? int'($urandom_range(0, 3)) : 0;
    end
  endtask

  task automatic run(input int noresp, input bit spur);
    int b;
    int guard;
    @(negedge clk_p);
    b = cyc;
    build_run(b, noresp);
    noresp_head = noresp;
    spur_en = spur;
    input_valid_n = 1'b0;
    guard = 0;
    do begin
      @(negedge clk_p);
      input_valid_n = (spur && busy && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      guard++;
    end while (exp_q.size() != 0 && guard < 3000);
    input_valid_n = 1'b1;
    spur_en = 1'b0;
    noresp_head = -1;
    if (guard >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL run_timeout: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk_p);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_head_sel"}, int'(head_sel), 0);
    check_val({tag, "_eng_valid_n"}, int'(eng_valid_n), 1);
    check_val({tag, "_wr_en_n"}, int'(wr_en_n), 1);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_output_valid_n"}, int'(output_valid_n), 1);
    check_val({tag, "_error_n"}, int'(error_n), 1);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    input_valid_n = 1'b1;
    set_profile(5, 1'b0);
    #13;
    check_reset_outputs("reset");
    @(negedge clk_p);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_p);

    // Full run with L=5, gap 1, sink always ready.
    run(-1, 1'b0);
    // Backpressure on head 3 only.
    stall[3] = 4;
    run(-1, 1'b0);
    // Spurious starts and stray engine strobes with random latencies and stalls.
    set_profile(0, 1'b1);
    run(-1, 1'b1);
    for (int r = 0; r < 3; r++) begin
      set_profile(0, 1'b1);
      run(-1, (r % 2) == 1);
    end

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
    set_profile(0, 1'b1);
    run(2, 1'b0);
    check_val("error_sticky_idle", int'(error_n), 0);
    set_profile(0, 1'b1);
    run(-1, 1'b0);
    check_val("error_cleared", int'(error_n), 1);
`endif

    // Reset while head 5 is waiting on the engine, then a fresh run.
    set_profile(0, 1'b1);
    @(negedge clk_p);
    build_run(cyc, -1);
    input_valid_n = 1'b0;
    @(negedge clk_p);
    input_valid_n = 1'b1;
    guard = 0;
    while (!(!eng_valid_n && head_sel == 4'd5) && guard < 2000) begin
      @(negedge clk_p);
      guard++;
    end
    check_val("reached_head5_launch", int'(guard < 2000), 1);
    @(negedge clk_p);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    repeat (3) @(negedge clk_p);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_p);
    set_profile(0, 1'b1);
    run(-1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
